// File: rtl/instr_decoder.sv
// instr_decoder: multi-cycle decoder/sequencer that drives the register file, ALU, SRAM, PC and LCD controls
// Every data/address output is registered and holds its value until a later instruction overwrites it
module instr_decoder (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       cmd_start,
    input  logic [7:0] instr_byte,
    input  logic [7:0] operand1,
    input  logic [7:0] operand2,
    input  logic       lcd_done,
    input  logic [7:0] reg_a,
    input  logic [7:0] reg_b,
    input  logic [7:0] reg_c,
    input  logic [7:0] reg_d,
    input  logic [7:0] reg_flags,
    input  logic [7:0] res,
    input  logic [7:0] sram_rd_data,
    output logic       pc_hlt,
    output logic       jmp_en,
    output logic [8:0] jmp_addr,
    output logic [1:0] instr_size,
    output logic [7:0] sram_addr,
    output logic       sram_rd_en,
    output logic       sram_wr_en,
    output logic [7:0] sram_wr_data,
    output logic [7:0] lcd_data,
    output logic [7:0] data_loc,
    output logic       loc_req,
    output logic       strt,
    output logic [7:0] reg_wr_data,
    output logic [1:0] reg_wr_addr,
    output logic       reg_wr_en,
    output logic [2:0] alu_inst,
    output logic [7:0] op_1,
    output logic [7:0] op_2
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, ALU_WAIT, MEM_WAIT, LCD_WAIT, WB} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_instr, r_op1, r_op2;
    logic [1:0] w_dst, w_src, w_size;
    logic [7:0] w_dst_val, w_src_val;
    logic       w_start, w_alu, w_movr, w_movi, w_ld, w_st, w_jmp, w_out, w_loc, w_hlt, w_unary, w_taken;
    logic       w_unused;
    assign w_dst     = r_instr[3:2];
    assign w_src     = r_instr[1:0];
    assign w_dst_val = w_dst[1] ? (w_dst[0] ? reg_d : reg_c) : (w_dst[0] ? reg_b : reg_a);
    assign w_src_val = w_src[1] ? (w_src[0] ? reg_d : reg_c) : (w_src[0] ? reg_b : reg_a);
    assign w_alu     = r_instr[7];
    assign w_movr    = r_instr[7:4] == 4'b0000;
    assign w_movi    = r_instr[7:4] == 4'b0001;
    assign w_ld      = r_instr[7:4] == 4'b0010;
    assign w_st      = r_instr[7:4] == 4'b0011;
    assign w_jmp     = r_instr[7:2] == 6'b010100;
    assign w_out     = r_instr[7:2] == 6'b010000;
    assign w_loc     = r_instr[7:4] == 4'b0110;
    assign w_hlt     = r_instr == 8'h7F;
    assign w_unary   = r_instr[6:4] == 3'd3 || r_instr[6:5] == 2'b11;
    assign w_taken   = w_src == 2'd0 || (w_src == 2'd1 && reg_flags[1]) ||
                       (w_src == 2'd2 && !reg_flags[1]) || (w_src == 2'd3 && reg_flags[0]);
    assign w_start   = r_state == IDLE && cmd_start && !pc_hlt;
    assign w_size    = ((instr_byte[7:6] == 2'b00 && instr_byte[5:4] != 2'b00) ||
                        instr_byte[7:2] == 6'b010100 || instr_byte[7:4] == 4'b0110) ? 2'd2 : 2'd1;
    // operand2 and the upper flag bits are carried but never consumed
    assign w_unused  = &{1'b0, r_op2, reg_flags[7:2]};

    always_ff @(posedge clk or negedge sys_rst)
        if (!sys_rst) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_start ? DECODE : IDLE;
            DECODE:   w_next = EXEC;
            EXEC:     w_next = w_alu ? ALU_WAIT : w_ld ? MEM_WAIT : (w_out || w_loc) ? LCD_WAIT : IDLE;
            ALU_WAIT: w_next = WB;
            MEM_WAIT: w_next = IDLE;
            LCD_WAIT: w_next = lcd_done ? IDLE : LCD_WAIT;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            {r_instr, r_op1, r_op2} <= '0;
            {pc_hlt, jmp_en, jmp_addr, instr_size} <= '0;
            {sram_addr, sram_rd_en, sram_wr_en, sram_wr_data} <= '0;
            {lcd_data, data_loc, loc_req, strt} <= '0;
            {reg_wr_data, reg_wr_addr, reg_wr_en} <= '0;
            {alu_inst, op_1, op_2} <= '0;
        end else begin
            reg_wr_en  <= 1'b0;
            sram_wr_en <= 1'b0;
            jmp_en     <= 1'b0;
            case (r_state)
                IDLE: if (w_start) begin
                    r_instr    <= instr_byte;
                    r_op1      <= operand1;
                    r_op2      <= operand2;
                    instr_size <= w_size;
                    jmp_addr   <= 9'd0;
                end
                DECODE: begin
                    if (w_alu) begin
                        op_1     <= w_dst_val;
                        op_2     <= w_unary ? 8'd0 : w_src_val;
                        alu_inst <= r_instr[6:4];
                    end
                    if (w_ld || w_st) sram_addr <= r_op1;
                    if (w_ld) sram_rd_en <= 1'b1;
                    if (w_st) sram_wr_data <= w_dst_val;
                end
                EXEC: begin
                    if (w_movr || w_movi) begin
                        reg_wr_addr <= w_dst;
                        reg_wr_data <= w_movr ? w_src_val : r_op1;
                        reg_wr_en   <= 1'b1;
                    end
                    if (w_st) sram_wr_en <= 1'b1;
                    if (w_jmp && w_taken) begin
                        jmp_addr <= {1'b0, r_op1};
                        jmp_en   <= 1'b1;
                    end
                    if (w_out) begin
                        lcd_data <= w_src_val;
                        strt     <= 1'b1;
                    end
                    if (w_loc) begin
                        data_loc <= r_op1;
                        loc_req  <= 1'b1;
                    end
                    if (w_hlt) pc_hlt <= 1'b1;
                end
                MEM_WAIT: begin
                    reg_wr_data <= sram_rd_data;
                    reg_wr_addr <= w_dst;
                    reg_wr_en   <= 1'b1;
                    sram_rd_en  <= 1'b0;
                end
                ALU_WAIT: begin
                    reg_wr_data <= res;
                    reg_wr_addr <= w_dst;
                    reg_wr_en   <= 1'b1;
                end
                LCD_WAIT: if (lcd_done) begin
                    strt    <= 1'b0;
                    loc_req <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: directed table, randomized model comparison and hand sequences for instr_decoder
module tb_instr_decoder;
    logic       clk = 1'b0, sys_rst = 1'b0, cmd_start = 1'b0, lcd_done = 1'b1;
    logic [7:0] instr_byte = '0, operand1 = '0, operand2 = '0;
    logic [7:0] reg_a = '0, reg_b = '0, reg_c = '0, reg_d = '0, reg_flags = '0, res = '0, sram_rd_data = '0;
    logic       pc_hlt, jmp_en, sram_rd_en, sram_wr_en, loc_req, strt, reg_wr_en;
    logic [8:0] jmp_addr;
    logic [1:0] instr_size, reg_wr_addr;
    logic [7:0] sram_addr, sram_wr_data, lcd_data, data_loc, reg_wr_data, op_1, op_2;
    logic [2:0] alu_inst;
    logic [78:0] all_out;
    int errors = 0, checks = 0;

    instr_decoder dut (
        .clk(clk), .sys_rst(sys_rst), .cmd_start(cmd_start), .instr_byte(instr_byte),
        .operand1(operand1), .operand2(operand2), .lcd_done(lcd_done),
        .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d), .reg_flags(reg_flags),
        .res(res), .sram_rd_data(sram_rd_data), .pc_hlt(pc_hlt), .jmp_en(jmp_en),
        .jmp_addr(jmp_addr), .instr_size(instr_size), .sram_addr(sram_addr),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_wr_data(sram_wr_data),
        .lcd_data(lcd_data), .data_loc(data_loc), .loc_req(loc_req), .strt(strt),
        .reg_wr_data(reg_wr_data), .reg_wr_addr(reg_wr_addr), .reg_wr_en(reg_wr_en),
        .alu_inst(alu_inst), .op_1(op_1), .op_2(op_2)
    );

    assign all_out = {pc_hlt, jmp_en, jmp_addr, instr_size, sram_addr, sram_rd_en, sram_wr_en, sram_wr_data,
                      lcd_data, data_loc, loc_req, strt, reg_wr_data, reg_wr_addr, reg_wr_en, alu_inst, op_1, op_2};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] rwa, sz;
        logic [7:0] rwd, sa, swd, o1, o2, lcd, loc;
        logic [2:0] ai;
        logic [8:0] ja;
        logic       hlt, rd, st, lq;
        int         nrw, nsw, nj;
    } st_t;
    st_t m, o;

    typedef struct {
        logic [7:0] ins, op1, fl;
        logic [1:0] rwa;
        logic [7:0] rwd, sa, swd, o1, o2;
        logic [2:0] ai;
        logic [8:0] ja;
        int         nrw, nsw, nj;
    } vec_t;
    vec_t tv[21];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // architectural effect of one instruction, from the opcode map
    function automatic void model_step(input logic [7:0] ins, input logic [7:0] op1);
        logic [7:0] r [4];
        int cat, d, s, op;
        logic taken;
        r = '{reg_a, reg_b, reg_c, reg_d};
        d = int'(ins / 4) % 4;
        s = int'(ins) % 4;
        op = int'(ins / 16) % 8;
        cat = int'(ins / 16);
        m.nrw = 0; m.nsw = 0; m.nj = 0; m.rd = 0; m.st = 0; m.lq = 0;
        if (m.hlt) return;
        m.ja = 9'd0;
        m.sz = ((cat >= 1 && cat <= 3) || (ins >= 8'h50 && ins <= 8'h53) || cat == 6) ? 2'd2 : 2'd1;
        if (cat >= 8) begin
            m.o1 = r[d];
            m.o2 = (op == 3 || op == 6 || op == 7) ? 8'd0 : r[s];
            m.ai = 3'(op);
            m.rwa = 2'(d); m.rwd = res; m.nrw = 1;
        end else if (cat == 0) begin
            m.rwa = 2'(d); m.rwd = r[s]; m.nrw = 1;
        end else if (cat == 1) begin
            m.rwa = 2'(d); m.rwd = op1; m.nrw = 1;
        end else if (cat == 2) begin
            m.sa = op1; m.rwa = 2'(d); m.rwd = sram_rd_data; m.nrw = 1; m.rd = 1;
        end else if (cat == 3) begin
            m.sa = op1; m.swd = r[d]; m.nsw = 1;
        end else if (ins >= 8'h40 && ins <= 8'h43) begin
            m.lcd = r[s]; m.st = 1;
        end else if (ins >= 8'h50 && ins <= 8'h53) begin
            taken = s == 0 || (s == 1 && reg_flags[1]) || (s == 2 && !reg_flags[1]) || (s == 3 && reg_flags[0]);
            m.ja = taken ? {1'b0, op1} : 9'd0;
            m.nj = taken ? 1 : 0;
        end else if (cat == 6) begin
            m.loc = op1; m.lq = 1;
        end else if (ins == 8'h7F) begin
            m.hlt = 1;
        end
    endfunction

    task automatic run(input logic [7:0] ins, input logic [7:0] op1);
        instr_byte = ins; operand1 = op1; operand2 = 8'($urandom); cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        o.nrw = 0; o.nsw = 0; o.nj = 0; o.rd = 0; o.st = 0; o.lq = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            o.nrw += int'(reg_wr_en);
            o.nsw += int'(sram_wr_en);
            o.nj  += int'(jmp_en);
            o.rd |= sram_rd_en; o.st |= strt; o.lq |= loc_req;
            if (k == 3) begin
                o.rwa = reg_wr_addr; o.rwd = reg_wr_data; o.sa = sram_addr; o.swd = sram_wr_data;
                o.o1 = op_1; o.o2 = op_2; o.ai = alu_inst; o.ja = jmp_addr; o.lcd = lcd_data;
                o.loc = data_loc; o.sz = instr_size; o.hlt = pc_hlt;
            end
        end
    endtask

    task automatic cmp(input string t);
        chk({t, ".rwa"}, 80'(o.rwa), 80'(m.rwa));
        chk({t, ".rwd"}, 80'(o.rwd), 80'(m.rwd));
        chk({t, ".sa"},  80'(o.sa),  80'(m.sa));
        chk({t, ".swd"}, 80'(o.swd), 80'(m.swd));
        chk({t, ".op1"}, 80'(o.o1),  80'(m.o1));
        chk({t, ".op2"}, 80'(o.o2),  80'(m.o2));
        chk({t, ".ai"},  80'(o.ai),  80'(m.ai));
        chk({t, ".ja"},  80'(o.ja),  80'(m.ja));
        chk({t, ".lcd"}, 80'(o.lcd), 80'(m.lcd));
        chk({t, ".loc"}, 80'(o.loc), 80'(m.loc));
        chk({t, ".sz"},  80'(o.sz),  80'(m.sz));
        chk({t, ".hlt"}, 80'(o.hlt), 80'(m.hlt));
        chk({t, ".nrw"}, 80'(o.nrw), 80'(m.nrw));
        chk({t, ".nsw"}, 80'(o.nsw), 80'(m.nsw));
        chk({t, ".nj"},  80'(o.nj),  80'(m.nj));
        chk({t, ".rd"},  80'(o.rd),  80'(m.rd));
        chk({t, ".strt"}, 80'(o.st), 80'(m.st));
        chk({t, ".locrq"}, 80'(o.lq), 80'(m.lq));
        chk({t, ".rd_end"}, 80'(sram_rd_en), 80'(0));
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset.all", 80'(all_out), 80'(0));
        sys_rst = 1'b1;
        m = '{default: 0};
    endtask

    initial begin
        logic [7:0] ins, op1;
        int n;
        //        ins    op1    fl     rwa   rwd    sa     swd    o1     o2     ai    ja      nrw nsw nj
        tv[0]  = '{8'h01, 8'h00, 8'h00, 2'd0, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 9'h000, 1, 0, 0};
        tv[1]  = '{8'h1C, 8'h42, 8'h00, 2'd3, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 9'h000, 1, 0, 0};
        tv[2]  = '{8'h28, 8'h51, 8'h00, 2'd2, 8'h5C, 8'h51, 8'h00, 8'h00, 8'h00, 3'd0, 9'h000, 1, 0, 0};
        tv[3]  = '{8'h34, 8'h75, 8'h00, 2'd2, 8'h5C, 8'h75, 8'h22, 8'h00, 8'h00, 3'd0, 9'h000, 0, 1, 0};
        tv[4]  = '{8'h81, 8'h00, 8'h00, 2'd0, 8'hAA, 8'h75, 8'h22, 8'h11, 8'h22, 3'd0, 9'h000, 1, 0, 0};
        tv[5]  = '{8'h9B, 8'h00, 8'h00, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h44, 3'd1, 9'h000, 1, 0, 0};
        tv[6]  = '{8'hA1, 8'h00, 8'h00, 2'd0, 8'hAA, 8'h75, 8'h22, 8'h11, 8'h22, 3'd2, 9'h000, 1, 0, 0};
        tv[7]  = '{8'hB8, 8'h00, 8'h00, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd3, 9'h000, 1, 0, 0};
        tv[8]  = '{8'hCB, 8'h00, 8'h00, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h44, 3'd4, 9'h000, 1, 0, 0};
        tv[9]  = '{8'hD1, 8'h00, 8'h00, 2'd0, 8'hAA, 8'h75, 8'h22, 8'h11, 8'h22, 3'd5, 9'h000, 1, 0, 0};
        tv[10] = '{8'hEC, 8'h00, 8'h00, 2'd3, 8'hAA, 8'h75, 8'h22, 8'h44, 8'h00, 3'd6, 9'h000, 1, 0, 0};
        tv[11] = '{8'hF8, 8'h00, 8'h00, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h000, 1, 0, 0};
        tv[12] = '{8'h50, 8'h62, 8'h00, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h062, 0, 0, 1};
        tv[13] = '{8'h51, 8'h57, 8'h02, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h057, 0, 0, 1};
        tv[14] = '{8'h51, 8'h57, 8'h00, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h000, 0, 0, 0};
        tv[15] = '{8'h52, 8'h3C, 8'h09, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h03C, 0, 0, 1};
        tv[16] = '{8'h52, 8'h3C, 8'h02, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h000, 0, 0, 0};
        tv[17] = '{8'h53, 8'h7E, 8'h01, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h07E, 0, 0, 1};
        tv[18] = '{8'h53, 8'h7E, 8'h00, 2'd2, 8'hAA, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h000, 0, 0, 0};
        tv[19] = '{8'h05, 8'h00, 8'h00, 2'd1, 8'h22, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h000, 1, 0, 0};
        tv[20] = '{8'h55, 8'h12, 8'h00, 2'd1, 8'h22, 8'h75, 8'h22, 8'h33, 8'h00, 3'd7, 9'h000, 0, 0, 0};

        do_reset();
        reg_a = 8'h11; reg_b = 8'h22; reg_c = 8'h33; reg_d = 8'h44; res = 8'hAA; sram_rd_data = 8'h5C;
        foreach (tv[i]) begin
            reg_flags = tv[i].fl;
            run(tv[i].ins, tv[i].op1);
            chk($sformatf("tv%0d.rwa", i), 80'(o.rwa), 80'(tv[i].rwa));
            chk($sformatf("tv%0d.rwd", i), 80'(o.rwd), 80'(tv[i].rwd));
            chk($sformatf("tv%0d.sa", i),  80'(o.sa),  80'(tv[i].sa));
            chk($sformatf("tv%0d.swd", i), 80'(o.swd), 80'(tv[i].swd));
            chk($sformatf("tv%0d.op1", i), 80'(o.o1),  80'(tv[i].o1));
            chk($sformatf("tv%0d.op2", i), 80'(o.o2),  80'(tv[i].o2));
            chk($sformatf("tv%0d.ai", i),  80'(o.ai),  80'(tv[i].ai));
            chk($sformatf("tv%0d.ja", i),  80'(o.ja),  80'(tv[i].ja));
            chk($sformatf("tv%0d.nrw", i), 80'(o.nrw), 80'(tv[i].nrw));
            chk($sformatf("tv%0d.nsw", i), 80'(o.nsw), 80'(tv[i].nsw));
            chk($sformatf("tv%0d.nj", i),  80'(o.nj),  80'(tv[i].nj));
            chk($sformatf("tv%0d.rd", i),  80'(o.rd),  80'(tv[i].ins == 8'h28));
        end

        do_reset();
        for (int i = 0; i < 120; i++) begin
            reg_a = 8'($urandom); reg_b = 8'($urandom); reg_c = 8'($urandom); reg_d = 8'($urandom);
            reg_flags = 8'($urandom); res = 8'($urandom); sram_rd_data = 8'($urandom); lcd_done = 1'b1;
            ins = 8'($urandom);
            if (ins == 8'h7F) ins = 8'h80;
            op1 = 8'($urandom);
            model_step(ins, op1);
            run(ins, op1);
            cmp($sformatf("rnd%0d_%02h", i, ins));
        end

        reg_c = 8'h33; lcd_done = 1'b0;
        model_step(8'h42, 8'h00);
        instr_byte = 8'h42; operand1 = 8'h00; cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("out.strt", 80'(strt), 80'(1));
        chk("out.data", 80'(lcd_data), 80'(8'h33));
        repeat (4) @(posedge clk);
        #1 chk("out.hold", 80'(strt), 80'(1));
        lcd_done = 1'b1;
        @(posedge clk);
        #1 chk("out.rel", 80'(strt), 80'(0));
        lcd_done = 1'b0;
        model_step(8'h6A, 8'h99);
        instr_byte = 8'h6A; operand1 = 8'h99; cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("loc.req", 80'(loc_req), 80'(1));
        chk("loc.data", 80'(data_loc), 80'(8'h99));
        repeat (3) @(posedge clk);
        #1 chk("loc.hold", 80'(loc_req), 80'(1));
        lcd_done = 1'b1;
        @(posedge clk);
        #1 chk("loc.rel", 80'(loc_req), 80'(0));
        chk("loc.sz", 80'(instr_size), 80'(2));

        model_step(8'h7F, 8'h00);
        run(8'h7F, 8'h00);
        cmp("hlt");
        reg_a = 8'h5A; reg_b = 8'hA5;
        model_step(8'h01, 8'h00);
        run(8'h01, 8'h00);
        cmp("halted");
        model_step(8'h34, 8'h10);
        run(8'h34, 8'h10);
        cmp("halted_st");

        do_reset();
        reg_a = 8'h11; reg_b = 8'h22;
        instr_byte = 8'h81; cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        @(posedge clk);
        #1 chk("midrst.op1", 80'(op_1), 80'(8'h11));
        @(posedge clk);
        #2 sys_rst = 1'b0;
        #1 chk("midrst.all", 80'(all_out), 80'(0));
        repeat (2) @(posedge clk);
        #1 sys_rst = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            n += int'(reg_wr_en);
        end
        chk("midrst.nrw", 80'(n), 80'(0));
        chk("midrst.idle", 80'(all_out), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
- Multi-cycle instruction decoder/sequencer for the 8-bit CPU.
- Captures an opcode and its operands on a start pulse, then drives:
  - register-file write port,
  - ALU operand/opcode lines,
  - SRAM read/write port,
  - PC jump/halt controls,
  - LCD output handshake.
- Sits between program memory/PC and the register file, ALU, SRAM and LCD controller.

Parameters:
- none (8-bit datapath and 9-bit jump address are fixed)

Ports:
- clk  in  1  system clock, rising edge
- sys_rst  in  1  asynchronous active-low reset
- cmd_start  in  1  one-cycle pulse; start decoding instr_byte/operand1/operand2
- instr_byte  in  8  opcode
- operand1  in  8  first operand (imm / address)
- operand2  in  8  second operand (reserved, latched only)
- lcd_done  in  1  LCD controller finished current transfer
- reg_a, reg_b, reg_c, reg_d  in  8 each  register file contents
- reg_flags  in  8  bit0 = overflow, bit1 = zero
- res  in  8  ALU result
- sram_rd_data  in  8  SRAM read data
- pc_hlt  out  1  halt PC (sticky)
- jmp_en  out  1  jump strobe
- jmp_addr  out  9  jump target, {1'b0, operand1}
- instr_size  out  2  instruction length in bytes (1 or 2)
- sram_addr  out  8  SRAM address
- sram_rd_en  out  1  SRAM read enable
- sram_wr_en  out  1  SRAM write enable
- sram_wr_data  out  8  SRAM write data
- lcd_data  out  8  byte to LCD
- data_loc  out  8  LCD cursor location
- loc_req  out  1  cursor-set request
- strt  out  1  LCD character-write request
- reg_wr_data  out  8  register write data
- reg_wr_addr  out  2  00 = A, 01 = B, 10 = C, 11 = D
- reg_wr_en  out  1  register write strobe
- alu_inst  out  3  ALU opcode
- op_1, op_2  out  8 each  ALU operands

Behaviour:
- Reset (sys_rst low, asynchronous):
  - all outputs 0, state IDLE, latched instruction 0.
  - Reset mid-instruction aborts it; no strobes remain asserted.
- Encoding: `dst` = instr[3:2], `src` = instr[1:0], register index order A, B, C, D.
  - 00_00_dd_ss: MOV dst, src (size 1)
  - 00_01_dd_xx: MOV dst, operand1 (size 2)
  - 00_10_dd_xx: MOV dst, [operand1] (size 2)
  - 00_11_ss_xx: MOV [operand1], ss (size 2); ss = instr[3:2]
  - 1_ooo_dd_ss: ALU op ooo on dst, src (size 1)
    - ooo: 000 AND, 001 OR, 010 XOR, 011 NOT, 100 ADD, 101 SUB, 110 INC, 111 DEC
    - unary ops (NOT, INC, DEC) drive op_2 = 0
  - 0101_00cc: jumps to operand1 (size 2)
    - cc: 00 JMP always, 01 JZ (flags[1] = 1), 10 JNZ (flags[1] = 0), 11 JOV (flags[0] = 1)
  - 0100_00ss: OUT ss to LCD (size 1)
  - 0110_xxxx: LOC operand1 (size 2)
  - 0111_1111: HLT (size 1)
  - all other codes: NOP (size 1)
- States: IDLE, DECODE, EXEC, ALU_WAIT, MEM_WAIT, LCD_WAIT, WB.
- IDLE:
  - cmd_start = 1 at a rising edge (edge E0): latch instr_byte and operands, set instr_size.
  - Clear jmp_en and jmp_addr (= 0), go DECODE.
  - cmd_start is ignored outside IDLE; cmd_start while pc_hlt = 1 is ignored.
- DECODE (E1), then EXEC:
  - ALU: drive op_1 = reg[dst], op_2 = reg[src] or 0, alu_inst = ooo.
  - load: sram_addr = operand1, sram_rd_en = 1.
  - store: sram_addr = operand1, sram_wr_data = reg[ss].
- EXEC (E2):
  - MOV reg/imm: reg_wr_addr = dst, reg_wr_data = source value, reg_wr_en pulse 1 cycle; back to IDLE.
  - store: sram_wr_en pulse 1 cycle; back to IDLE.
  - load: to MEM_WAIT.
  - ALU: to ALU_WAIT.
  - jump taken: jmp_addr = {0, operand1}, jmp_en pulse 1 cycle.
  - jump not taken: jmp_addr stays 0, jmp_en stays 0.
  - OUT: lcd_data = reg[ss], strt = 1, go LCD_WAIT.
  - LOC: data_loc = operand1, loc_req = 1, go LCD_WAIT.
  - HLT: pc_hlt = 1 until reset.
- MEM_WAIT (E3):
  - reg_wr_data = sram_rd_data, reg_wr_addr = dst, reg_wr_en pulse.
  - sram_rd_en drops; go IDLE.
- ALU_WAIT → WB (E3):
  - reg_wr_data = res, reg_wr_addr = dst, reg_wr_en pulse; go IDLE.
- LCD_WAIT:
  - Hold strt/loc_req until lcd_done = 1, then deassert and go IDLE.
  - lcd_done already high on entry completes on the next edge.
- Hold rules:
  - All data/address outputs (reg_wr_*, sram_addr, sram_wr_data, op_1, op_2, alu_inst, jmp_addr, lcd_data, data_loc) hold their last value until overwritten by a later instruction.
  - Strobes (reg_wr_en, sram_wr_en, jmp_en) are single-cycle.
- Latency: every instruction completes by E3; results are stable 3 edges after E0.

Test Plan:
- Reset:
  - regs A = 0x11, B = 0x22, C = 0x33, D = 0x44.
  - 0x01 (MOV A,B) → reg_wr_addr = 00, reg_wr_data = 0x22.
  - 0x1C with operand1 = 0x42 → reg_wr_addr = 11, reg_wr_data = 0x42.
- Load/store:
  - 0x28 with op1 = 0x51 → sram_addr = 0x51, sram_rd_en seen, reg_wr_addr = 10.
  - 0x34 with op1 = 0x75 → sram_addr = 0x75, sram_wr_data = 0x22, sram_wr_en pulse.
- ALU sweep, each after 4 edges:
  - 0x81 → op_1 = 0x11, op_2 = 0x22, alu_inst = 0
  - 0x9B → C, D, 1
  - 0xA1 → 2
  - 0xB8 → op_1 = 0x33, op_2 = 0, alu_inst = 3
  - 0xCB → 4
  - 0xD1 → 5
  - 0xEC → op_1 = 0x44, op_2 = 0, alu_inst = 6
  - 0xF8 → 7
  - each: writeback of res = 0xAA to dst.
- Jumps:
  - 0x50 with op1 = 0x62 → jmp_addr = 0x062.
  - 0x51 with flags 0x02 → jmp_addr = 0x057.
  - 0x51 with flags 0x00 → jmp_addr = 0, jmp_en = 0.
  - 0x52 with flags 0x09 → jmp_addr = op1; with flags 0x02 → not taken.
  - 0x53 with flags 0x01 → taken; with flags 0x00 → not taken.
- HLT/LCD/reset:
  - 0x7F → pc_hlt = 1 and later cmd_start ignored.
  - 0x42 → lcd_data = 0x33, strt held until lcd_done.
  - sys_rst low mid-ALU → all outputs 0.
